// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port synchronous RAM between the CPU
//                instruction-fetch port and data port. One access at a time,
//                round-robin on conflict, one-cycle ready pulse per access.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    // RAM side
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_access = 2'd1;
    localparam logic [1:0] c_wait   = 2'd2;
    localparam logic [1:0] c_done   = 2'd3;

    localparam logic [3:0] c_lat    = 4'(RAM_LATENCY);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [3:0] r_cnt;
    logic       r_gnt_d;     // 1: current access belongs to the data port
    logic       r_we;        // current access is a store
    logic       r_last_d;    // 1: last grant went to the data port
    logic       w_any_req;
    logic       w_grant_d;
    logic       w_capture;

    // Data port wins when alone, or on conflict when the fetch port had the
    // previous grant (reset leaves last grant = fetch, so first conflict -> D).
    assign w_any_req = i_req | d_req;
    assign w_grant_d = d_req & (~i_req | ~r_last_d);
    assign w_capture = (r_state == c_wait) && (r_cnt == 4'd1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: IDLE -> ACCESS -> WAIT -> DONE -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:   if (w_any_req) w_next_state = c_access;
            c_access: w_next_state = c_wait;
            c_wait:   if (r_cnt == 4'd1) w_next_state = c_done;
            c_done:   w_next_state = c_idle;
            default:  w_next_state = c_idle;
        endcase
    end

    // Registered datapath and outputs, updated per state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_gnt_d   <= 1'b0;
            r_we      <= 1'b0;
            r_last_d  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_any_req) begin
                        // Launch the access directly into the RAM-side registers
                        // so mem_ce appears in the cycle after the grant.
                        mem_ce   <= 1'b1;
                        busy     <= 1'b1;
                        r_gnt_d  <= w_grant_d;
                        r_last_d <= w_grant_d;
                        if (w_grant_d) begin
                            r_we      <= d_we;
                            mem_we    <= d_we;
                            mem_sel   <= d_sel;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            r_we      <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_sel   <= 4'b1111;
                            mem_addr  <= i_addr;
                        end
                    end
                end
                c_access: begin
                    mem_ce <= 1'b0;
                    mem_we <= 1'b0;
                    r_cnt  <= c_lat;
                end
                c_wait: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_capture) begin
                        if (r_gnt_d) begin
                            if (!r_we) d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ready <= 1'b1;
                        end
                    end
                end
                c_done: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    mem_ce  <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter
//                (RAM_LATENCY=1 instance plus a RAM_LATENCY=3 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // RAM_LATENCY = 1 instance
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_sel = '0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ready, d_ready, mem_ce, mem_we, busy;
    logic [3:0]  mem_sel;

    // RAM_LATENCY = 3 instance
    logic        i3_req = 1'b0, d3_req = 1'b0, d3_we = 1'b0;
    logic [31:0] i3_addr = '0, d3_addr = '0, d3_wdata = '0;
    logic [3:0]  d3_sel = '0;
    logic [31:0] i3_rdata, d3_rdata, mem3_addr, mem3_wdata, mem3_rdata;
    logic        i3_ready, d3_ready, mem3_ce, mem3_we, busy3;
    logic [3:0]  mem3_sel;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i3_req), .i_addr(i3_addr), .i_rdata(i3_rdata), .i_ready(i3_ready),
        .d_req(d3_req), .d_we(d3_we), .d_sel(d3_sel), .d_addr(d3_addr),
        .d_wdata(d3_wdata), .d_rdata(d3_rdata), .d_ready(d3_ready),
        .mem_ce(mem3_ce), .mem_we(mem3_we), .mem_sel(mem3_sel), .mem_addr(mem3_addr),
        .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata), .busy(busy3)
    );

    always #5 clk = ~clk;

    // RAM model: 64 words; read data is valid only in the cycle exactly
    // RAM_LATENCY after mem_ce, otherwise a poison pattern is presented.
    logic [31:0] ram [0:63];
    logic        r1_v;
    logic [31:0] r1_d;
    logic [2:0]  p_v;
    logic [31:0] p_d [0:2];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 64; k++) ram[k] <= {24'hC0FFEE, 2'b00, 6'(k)};
            ram[4]  <= 32'h24080005;
            ram[16] <= 32'h11223344;
            r1_v    <= 1'b0;
            p_v     <= 3'b000;
        end else begin
            if (mem_ce && mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_sel[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            r1_v   <= mem_ce && !mem_we;
            r1_d   <= ram[mem_addr[7:2]];
            p_v    <= {p_v[1:0], mem3_ce && !mem3_we};
            p_d[0] <= ram[mem3_addr[7:2]];
            p_d[1] <= p_d[0];
            p_d[2] <= p_d[1];
        end
    end

    assign mem_rdata  = r1_v   ? r1_d   : 32'hBAD0BAD0;
    assign mem3_rdata = p_v[2] ? p_d[2] : 32'hBAD0BAD0;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int ce_cnt;

        // ---------------- reset state ----------------
        rst = 1'b1;
        tick(); tick();
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_mem_ce",  32'(mem_ce),  32'd0);
        chk("rst_i_rdata", i_rdata,      32'd0);
        chk("rst_d_rdata", d_rdata,      32'd0);
        chk("rst_mem_sel", 32'(mem_sel), 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- 1: fetch only ----------------
        i_req = 1'b1; i_addr = 32'h10;                       // cycle 0
        tick();                                              // cycle 1
        chk("f_ce",   32'(mem_ce),  32'd1);
        chk("f_addr", mem_addr,     32'h10);
        chk("f_we",   32'(mem_we),  32'd0);
        chk("f_sel",  32'(mem_sel), 32'hF);
        chk("f_busy", 32'(busy),    32'd1);
        tick();                                              // cycle 2
        chk("f_ce_off", 32'(mem_ce),  32'd0);
        chk("f_rdy_c2", 32'(i_ready), 32'd0);
        tick();                                              // cycle 3
        chk("f_irdy",  32'(i_ready), 32'd1);
        chk("f_rdata", i_rdata,      32'h24080005);
        chk("f_drdy",  32'(d_ready), 32'd0);
        i_req = 1'b0;
        tick();                                              // cycle 4
        chk("f_irdy_pulse", 32'(i_ready), 32'd0);
        chk("f_rdata_hold", i_rdata,      32'h24080005);
        chk("f_idle_busy",  32'(busy),    32'd0);

        // ---------------- 3: store, then load back ----------------
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        tick();                                              // cycle 1
        chk("s_ce",    32'(mem_ce),  32'd1);
        chk("s_we",    32'(mem_we),  32'd1);
        chk("s_sel",   32'(mem_sel), 32'h3);
        chk("s_wdata", mem_wdata,    32'hDEADBEEF);
        chk("s_addr",  mem_addr,     32'h40);
        tick();                                              // cycle 2
        chk("s_we_off", 32'(mem_we), 32'd0);
        tick();                                              // cycle 3
        chk("s_drdy",  32'(d_ready), 32'd1);
        chk("s_irdy",  32'(i_ready), 32'd0);
        chk("s_rdata", d_rdata,      32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();                                              // idle
        d_req = 1'b1; d_addr = 32'h40;                       // load, cycle 0
        tick(); tick(); tick();                              // cycle 3
        chk("l_drdy",  32'(d_ready), 32'd1);
        chk("l_rdata", d_rdata,      32'h1122BEEF);
        d_req = 1'b0;
        tick();

        // ---------------- 2: conflict from reset ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        tick();                                              // cycle 1
        chk("c_first_addr", mem_addr, 32'h40);
        tick(); tick();                                      // cycle 3
        chk("c_drdy",  32'(d_ready), 32'd1);
        chk("c_irdy0", 32'(i_ready), 32'd0);
        chk("c_drdata", d_rdata,     32'h11223344);
        tick(); tick();                                      // cycle 5
        chk("c_second_ce",   32'(mem_ce), 32'd1);
        chk("c_second_addr", mem_addr,    32'h10);
        tick(); tick();                                      // cycle 7
        chk("c_irdy",  32'(i_ready), 32'd1);
        chk("c_drdy0", 32'(d_ready), 32'd0);
        chk("c_irdata", i_rdata,     32'h24080005);
        tick();
        // both requests stay asserted: grants must go D,I,D,I
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!mem_ce && n < 10) begin
                chk("rr_one_ready", 32'(i_ready & d_ready), 32'd0);
                tick();
                n++;
            end
            chk("rr_wait", 32'(n < 10), 32'd1);
            chk("rr_addr", mem_addr, (g % 2 == 0) ? 32'h40 : 32'h10);
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick(); tick();

        // ---------------- 4: reset mid-access ----------------
        i_req = 1'b1; i_addr = 32'h10;                       // cycle 0
        tick(); tick();                                      // cycle 2 (WAIT)
        rst = 1'b1;
        tick();                                              // cycle 3
        chk("r_busy",  32'(busy),    32'd0);
        chk("r_ce",    32'(mem_ce),  32'd0);
        chk("r_irdy",  32'(i_ready), 32'd0);
        chk("r_rdata", i_rdata,      32'd0);
        rst = 1'b0; i_req = 1'b0;
        tick();
        chk("r_irdy_after", 32'(i_ready), 32'd0);
        i_req = 1'b1; i_addr = 32'h10;                       // fresh fetch
        tick(); tick(); tick();
        chk("r_fresh_irdy",  32'(i_ready), 32'd1);
        chk("r_fresh_rdata", i_rdata,      32'h24080005);
        i_req = 1'b0;
        tick();

        // ---------------- 6: request dropped after grant ----------------
        i_req = 1'b1; i_addr = 32'h14;                       // cycle 0
        tick();                                              // cycle 1
        chk("d6_ce", 32'(mem_ce), 32'd1);
        i_req = 1'b0;
        tick(); tick();                                      // cycle 3
        chk("d6_irdy",  32'(i_ready), 32'd1);
        chk("d6_rdata", i_rdata,      32'hC0FFEE05);
        ce_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (mem_ce) ce_cnt++;
        end
        chk("d6_no_second_access", 32'(ce_cnt), 32'd0);

        // ---------------- 5: RAM_LATENCY = 3 ----------------
        i3_req = 1'b1; i3_addr = 32'h10;                     // cycle 0
        tick();                                              // cycle 1
        chk("l3_ce", 32'(mem3_ce), 32'd1);
        tick(); tick(); tick();                              // cycle 4
        chk("l3_rdy_c4", 32'(i3_ready), 32'd0);
        tick();                                              // cycle 5
        chk("l3_irdy",  32'(i3_ready), 32'd1);
        chk("l3_rdata", i3_rdata,      32'h24080005);
        i3_req = 1'b0;
        tick();
        chk("l3_pulse", 32'(i3_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
